// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// fetch_sequencer : instruction fetch/issue sequencer with halt, illegal-opcode
//                   and done-timeout supervision. Optional: FETCH_SINGLE_STEP_EN
// Revision 1.0
// ============================================================================
module fetch_sequencer #(
    parameter int ADDR_W       = 8,
    parameter int DONE_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              Resetn,
    input  logic              start,
    input  logic              halt_req,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [8:0]        mem_rdata,
    input  logic              mem_valid,
    output logic [8:0]        ir,
    output logic [8:0]        din,
    output logic              run,
    input  logic              done,
    input  logic              jmp,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              err
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_FWAIT  = 4'd2,
        S_DECODE = 4'd3,
        S_IMM    = 4'd4,
        S_IWAIT  = 4'd5,
        S_ISSUE  = 4'd6,
        S_EXEC   = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    // Timeout fires on the EXEC cycle that puts HALT exactly DONE_TIMEOUT cycles after run.
    localparam logic [7:0] TMO_LAST = 8'(DONE_TIMEOUT - 2);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [8:0]        ir_q, ir_d;
    logic [8:0]        din_q, din_d;
    logic              err_q, err_d;
    logic              pend_q, pend_d;
    logic [7:0]        tmo_q, tmo_d;
    logic              step_mode;
`ifdef FETCH_SINGLE_STEP_EN
    logic              step_q, step_d;
    assign step_mode = step_q;
`else
    assign step_mode = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            tmo_q   <= '0;
`ifdef FETCH_SINGLE_STEP_EN
            step_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            din_q   <= din_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            tmo_q   <= tmo_d;
`ifdef FETCH_SINGLE_STEP_EN
            step_q  <= step_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        din_d   = din_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        pend_d  = pend_q | (halt_req & (state_q != S_HALT));
`ifdef FETCH_SINGLE_STEP_EN
        step_d  = step_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) state_d = pend_d ? S_HALT : S_FETCH;
            end
            S_FETCH, S_FWAIT: begin
                if (mem_valid) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FWAIT;
                end
            end
            S_DECODE: begin
                case (ir_q[8:6])
                    3'b000, 3'b001, 3'b010: state_d = S_ISSUE;
                    3'b011, 3'b100:         state_d = S_IMM;
                    default: begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end
                endcase
            end
            S_IMM, S_IWAIT: begin
                if (mem_valid) begin
                    din_d   = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IWAIT;
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (done) begin
                    if (jmp) pc_d = ADDR_W'(din_q);
                    state_d = (pend_d || step_mode) ? S_HALT : S_FETCH;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
`ifdef FETCH_SINGLE_STEP_EN
                    step_d  = 1'b0;
                end else if (step) begin
                    state_d = S_FETCH;
                    step_d  = 1'b1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_HALT && state_q != S_HALT) pend_d = 1'b0;
    end

    assign mem_rd   = (state_q == S_FETCH) || (state_q == S_FWAIT) ||
                      (state_q == S_IMM)   || (state_q == S_IWAIT);
    assign mem_addr = pc_q;
    assign run      = (state_q == S_ISSUE);
    assign busy     = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted   = (state_q == S_HALT);
    assign err      = err_q;
    assign ir       = ir_q;
    assign din      = din_q;
    assign pc       = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fetch_sequencer : directed bench with wait-state memory and done responder
// Revision 1.0
// ============================================================================
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       Resetn, start, halt_req;
`ifdef FETCH_SINGLE_STEP_EN
    logic       step;
`endif
    logic [7:0] mem_addr, pc;
    logic       mem_rd, mem_valid, run, done, jmp, busy, halted, err;
    logic [8:0] mem_rdata, ir, din;

    logic [8:0] mem [256];
    int         waits, wcnt, done_lat, dcnt;
    int         n_vec = 0, n_miss = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_W(8), .DONE_TIMEOUT(15)) dut (
        .clk(clk), .Resetn(Resetn), .start(start), .halt_req(halt_req),
`ifdef FETCH_SINGLE_STEP_EN
        .step(step),
`endif
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .ir(ir), .din(din), .run(run), .done(done), .jmp(jmp), .pc(pc),
        .busy(busy), .halted(halted), .err(err)
    );

    // Memory with a fixed number of wait states per read
    assign mem_valid = mem_rd && (wcnt == waits);
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (!mem_rd || mem_valid) wcnt <= 0;
        else                      wcnt <= wcnt + 1;
    end

    // Control-FSM stand-in: done done_lat cycles after run (0 = never)
    always @(posedge clk) begin
        if (!Resetn)        dcnt <= 0;
        else if (run)       dcnt <= 1;
        else if (done)      dcnt <= 0;
        else if (dcnt != 0) dcnt <= dcnt + 1;
    end
    assign done = (done_lat != 0) && (dcnt == done_lat);
    assign jmp  = done && (ir[8:6] == 3'b100);

    task automatic do_reset();
        Resetn = 1'b0; start = 1'b0; halt_req = 1'b0;
`ifdef FETCH_SINGLE_STEP_EN
        step = 1'b0;
`endif
        for (int i = 0; i < 256; i++) mem[i] = 9'h080;
        waits = 0; done_lat = 1;
        repeat (2) @(negedge clk);
        Resetn = 1'b1;
    endtask

    task automatic wait_run(input int limit, input logic [8:0] want_ir, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            if (run === 1'b1 && ir === want_ir) found = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        Resetn = 1'b0; start = 1'b1; halt_req = 1'b0;
        waits = 0; done_lat = 1;
        repeat (3) @(negedge clk);
        n_vec++; if ({pc, mem_addr} !== 16'h0000) begin n_miss++;
            $display("FAIL reset_pc_addr: got pc=%h addr=%h expected 00 00", pc, mem_addr); end
        n_vec++; if ({ir, din} !== 18'h0) begin n_miss++;
            $display("FAIL reset_ir_din: got ir=%h din=%h expected 000 000", ir, din); end
        n_vec++; if ({mem_rd, run, busy, halted, err} !== 5'b0) begin n_miss++;
            $display("FAIL reset_flags: got rd,run,busy,halted,err=%b expected 00000",
                     {mem_rd, run, busy, halted, err}); end
        start = 1'b0;
    endtask

    task automatic test_add();
        do_reset();
        mem[0] = 9'h001; done_lat = 3;
        start = 1'b1; @(negedge clk); start = 1'b0;
        n_vec++; if ({mem_rd, busy, mem_addr} !== {2'b11, 8'h00}) begin n_miss++;
            $display("FAIL add_fetch: got rd=%b busy=%b addr=%h expected 1 1 00", mem_rd, busy, mem_addr); end
        @(negedge clk);
        n_vec++; if ({ir, pc} !== {9'h001, 8'h01}) begin n_miss++;
            $display("FAIL add_decode: got ir=%h pc=%h expected 001 01", ir, pc); end
        @(negedge clk);
        n_vec++; if (run !== 1'b1) begin n_miss++;
            $display("FAIL add_run: got %b expected 1", run); end
        @(negedge clk);
        n_vec++; if (run !== 1'b0) begin n_miss++;
            $display("FAIL add_run_width: got %b expected 0", run); end
        repeat (3) @(negedge clk);
        n_vec++; if ({mem_rd, mem_addr, pc} !== {1'b1, 8'h01, 8'h01}) begin n_miss++;
            $display("FAIL add_next_fetch: got rd=%b addr=%h pc=%h expected 1 01 01", mem_rd, mem_addr, pc); end
    endtask

    task automatic test_mvi_wait();
        bit found;
        do_reset();
        mem[0] = 9'h0D0; mem[1] = 9'h055; waits = 2; done_lat = 1;
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_run(40, 9'h0D0, found);
        n_vec++; if (found !== 1'b1) begin n_miss++;
            $display("FAIL mvi_run_timeout: got found=%b expected 1", found); end
        n_vec++; if ({din, pc} !== {9'h055, 8'h02}) begin n_miss++;
            $display("FAIL mvi_din: got din=%h pc=%h expected 055 02", din, pc); end
        repeat (2) @(negedge clk);
        n_vec++; if ({mem_rd, mem_addr, pc} !== {1'b1, 8'h02, 8'h02}) begin n_miss++;
            $display("FAIL mvi_next_fetch: got rd=%b addr=%h pc=%h expected 1 02 02", mem_rd, mem_addr, pc); end
    endtask

    task automatic test_jmp();
        bit found;
        do_reset();
        mem[5] = 9'h100; mem[6] = 9'h020; done_lat = 1;
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_run(80, 9'h100, found);
        n_vec++; if ({found, din, pc} !== {1'b1, 9'h020, 8'h07}) begin n_miss++;
            $display("FAIL jmp_issue: got found=%b din=%h pc=%h expected 1 020 07", found, din, pc); end
        repeat (2) @(negedge clk);
        n_vec++; if ({mem_rd, mem_addr, pc} !== {1'b1, 8'h20, 8'h20}) begin n_miss++;
            $display("FAIL jmp_target: got rd=%b addr=%h pc=%h expected 1 20 20", mem_rd, mem_addr, pc); end
    endtask

    task automatic test_illegal();
        bit seen = 1'b0;
        do_reset();
        mem[0] = 9'h1C0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int i = 0; i < 20 && halted !== 1'b1; i++) begin
            @(negedge clk);
            if (run === 1'b1) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_miss++;
            $display("FAIL illegal_run: got run seen=%b expected 0", seen); end
        n_vec++; if ({halted, err, busy, pc} !== {3'b110, 8'h01}) begin n_miss++;
            $display("FAIL illegal_halt: got halted=%b err=%b busy=%b pc=%h expected 1 1 0 01",
                     halted, err, busy, pc); end
        start = 1'b1; @(negedge clk); start = 1'b0;
        n_vec++; if ({mem_rd, mem_addr, err} !== {1'b1, 8'h01, 1'b1}) begin n_miss++;
            $display("FAIL illegal_resume: got rd=%b addr=%h err=%b expected 1 01 1", mem_rd, mem_addr, err); end
    endtask

    task automatic test_timeout();
        bit found;
        int first = 0;
        do_reset();
        mem[0] = 9'h001; done_lat = 0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_run(20, 9'h001, found);
        for (int k = 1; k <= 40 && first == 0; k++) begin
            @(negedge clk);
            if (halted === 1'b1) first = k;
        end
        n_vec++; if ({found, first} !== {1'b1, 32'd15}) begin n_miss++;
            $display("FAIL timeout_cycles: got found=%b halt after %0d expected 1 15", found, first); end
        n_vec++; if (err !== 1'b1) begin n_miss++;
            $display("FAIL timeout_err: got %b expected 1", err); end
    endtask

    task automatic test_halt();
        bit found;
        do_reset();
        mem[0] = 9'h001; done_lat = 3;
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_run(20, 9'h001, found);
        @(negedge clk); halt_req = 1'b1;
        @(negedge clk); halt_req = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if ({found, halted, mem_rd, pc} !== {3'b110, 8'h01}) begin n_miss++;
            $display("FAIL halt_exec: got found=%b halted=%b rd=%b pc=%h expected 1 1 0 01",
                     found, halted, mem_rd, pc); end
        repeat (3) @(negedge clk);
        n_vec++; if ({halted, mem_rd} !== 2'b10) begin n_miss++;
            $display("FAIL halt_hold: got halted=%b rd=%b expected 1 0", halted, mem_rd); end
        start = 1'b1; @(negedge clk); start = 1'b0;
        n_vec++; if ({mem_rd, mem_addr, halted} !== {1'b1, 8'h01, 1'b0}) begin n_miss++;
            $display("FAIL halt_resume: got rd=%b addr=%h halted=%b expected 1 01 0", mem_rd, mem_addr, halted); end

        // Wrap: jump to 0xFF, execute MV there, halt requested in its issue cycle
        do_reset();
        mem[0] = 9'h100; mem[1] = 9'h0FF; mem[255] = 9'h080; mem[2] = 9'h1FF;
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_run(30, 9'h100, found);
        @(negedge clk);
        wait_run(30, 9'h080, found);
        n_vec++; if ({found, pc} !== {1'b1, 8'h00}) begin n_miss++;
            $display("FAIL wrap_pc: got found=%b pc=%h expected 1 00", found, pc); end
        halt_req = 1'b1; @(negedge clk); halt_req = 1'b0;
        @(negedge clk);
        n_vec++; if ({halted, mem_rd, pc} !== {2'b10, 8'h00}) begin n_miss++;
            $display("FAIL wrap_halt: got halted=%b rd=%b pc=%h expected 1 0 00", halted, mem_rd, pc); end

        // Pending halt raised in IDLE short-circuits start
        do_reset();
        halt_req = 1'b1; @(negedge clk); halt_req = 1'b0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        n_vec++; if ({halted, mem_rd, pc} !== {2'b10, 8'h00}) begin n_miss++;
            $display("FAIL idle_halt: got halted=%b rd=%b pc=%h expected 1 0 00", halted, mem_rd, pc); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mvi_wait();
        test_jmp();
        test_illegal();
        test_timeout();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
